fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch sequencer that feeds the instruction register. On a fetch request from the control unit, it reads one instruction byte from program memory at the program counter using a request/acknowledge handshake. It then presents the byte on `DATA_OUT` and pulses `HIR` for one cycle so the instruction register captures it. It owns the program counter, which auto-increments with wrap-around and can be loaded by a jump. A wait-state timeout flags a memory that never acknowledges.

## Interface
- `ADDR_W`, default 8: program counter / memory address width.
- `TIMEOUT`, default 16: maximum cycles spent in `REQ` without `MEM_ACK` before aborting. Must be ≥ 2.
- `CLK` input 1: single clock; all logic is on the rising edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `FETCH` input 1: fetch request from the control unit; sampled only in `IDLE`.
- `JUMP` input 1: load the PC from `JUMP_ADDR`; sampled only in `IDLE`.
- `JUMP_ADDR` input `ADDR_W`: jump target.
- `CLR_ERR` input 1: clears the sticky `ERR` flag.
- `MEM_REQ` output 1: read request to program memory (registered).
- `MEM_ADDR` output `ADDR_W`: read address (registered); stable while `MEM_REQ`=1.
- `MEM_RDATA` input 8: read data; valid in a cycle where `MEM_ACK`=1.
- `MEM_ACK` input 1: memory acknowledge.
- `DATA_OUT` output 8: last fetched instruction byte; connects to the instruction register data input.
- `HIR` output 1: one-cycle load strobe to the instruction register.
- `PC` output `ADDR_W`: current program counter.
- `BUSY` output 1: high in any state other than `IDLE`.
- `ERR` output 1: sticky flag indicating a timeout occurred.

## Operation
- Reset values (`RESET_N`=0): state `IDLE`; `PC`=0; `MEM_REQ`=0; `MEM_ADDR`=0; `DATA_OUT`=8'h00; `HIR`=0; `ERR`=0; wait counter = 0. Reset takes effect immediately and aborts any fetch in flight.
- State `IDLE`:
  - `JUMP`=1 loads `PC`<=`JUMP_ADDR`.
  - `FETCH`=1 moves to `REQ`, with `MEM_REQ`<=1, `MEM_ADDR`<=fetch address, and counter<=0. The fetch address is `JUMP_ADDR` if `JUMP`=1 in the same cycle, otherwise `PC`.
  - `JUMP` and `FETCH` together: the jump takes effect and the fetch reads from `JUMP_ADDR`.
- State `REQ`: `MEM_REQ` held at 1 and `MEM_ADDR` held constant.
  - `MEM_ACK`=1: `DATA_OUT`<=`MEM_RDATA`, `PC`<=`MEM_ADDR`+1 (modulo 2^`ADDR_W`, so all-ones wraps to 0), `MEM_REQ`<=0, go to `LOAD`.
  - `MEM_ACK`=0 with counter = `TIMEOUT`-1: `ERR`<=1, `MEM_REQ`<=0, go to `IDLE`. `PC` and `DATA_OUT` are unchanged and `HIR` is not pulsed.
  - Otherwise: counter increments.
- State `LOAD`: `HIR`=1 for exactly this cycle; return to `IDLE`.
- `FETCH` and `JUMP` are ignored outside `IDLE`; the control unit must hold `FETCH` or re-assert it.
- `ERR` is sticky. `CLR_ERR`=1 clears it on the next edge. If a timeout and `CLR_ERR` occur in the same cycle, the set wins. `ERR` does not block new fetches.
- `MEM_ACK` arriving while not in `REQ` is ignored.

## Timing
- With `FETCH` sampled at edge k: `MEM_REQ`=1 after edge k.
- With `MEM_ACK` sampled at edge k+n (n ≥ 1): `DATA_OUT` is valid after edge k+n, `HIR`=1 from edge k+n to edge k+n+1, and `BUSY`=0 after edge k+n+1.
- The instruction register captures `DATA_OUT` at edge k+n+1.
- Zero-wait memory (ack in the first `REQ` cycle) gives a back-to-back fetch every 3 cycles.
- `PC` updates at the acknowledge edge, so it already points at the next byte while `HIR` is high.
- A timeout with no acknowledge returns `BUSY`=0 at edge k+`TIMEOUT`.

## Structure
- A shared package holds the state encoding (`IDLE`, `REQ`, `LOAD`) and the `INSTR_W`=8 constant used here and by the instruction register.
- One natural sub-module, `fetch_timer`, implements the wait-state counter with clear, enable, and terminal-count output.
- The rest is a single FSM plus `PC`/`DATA_OUT` registers.

## Test plan
- Reset then `FETCH` with a zero-wait memory returning 8'hA5 at address 0: `MEM_ADDR`=0, `DATA_OUT`=8'hA5, `HIR` high 1 cycle, `PC`=1, and 3 cycles from `FETCH` to `BUSY`=0.
- `MEM_ACK` delayed 5 cycles: `MEM_REQ`/`MEM_ADDR` stay stable throughout, and `HIR` fires exactly one cycle after the acknowledge.
- `JUMP_ADDR`=8'hFF with `JUMP` and `FETCH` together: fetch reads address 8'hFF, then `PC` wraps to 8'h00.
- No acknowledge with `TIMEOUT`=16: `MEM_REQ` drops after 16 cycles, `ERR`=1, no `HIR`, `PC` unchanged. `CLR_ERR` then clears `ERR`.
- `RESET_N` asserted mid-`REQ`: all outputs return to reset values asynchronously, and a later acknowledge is ignored.
- `FETCH` and `JUMP` pulsed during `REQ`/`LOAD`: ignored, and `PC` follows only the in-flight fetch.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch sequencer and the instruction register.
package fetch_unit_pkg;
  localparam int INSTR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// Program-memory read port: request/acknowledge handshake with address and read data.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic               MEM_REQ;
  logic [ADDR_W-1:0]  MEM_ADDR;
  logic [INSTR_W-1:0] MEM_RDATA;
  logic               MEM_ACK;

  modport master (output MEM_REQ, output MEM_ADDR, input MEM_RDATA, input MEM_ACK);
  modport slave  (input MEM_REQ, input MEM_ADDR, output MEM_RDATA, output MEM_ACK);
endinterface

// File: rtl/fetch_timer.sv
// Wait-state counter for the REQ state; TC marks the last cycle allowed without an acknowledge.
module fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic CLR,
  input  logic EN,
  output logic TC
);
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)  cnt_q <= '0;
    else if (CLR)  cnt_q <= '0;
    else if (EN)   cnt_q <= cnt_q + 1'b1;
  end

  assign TC = (cnt_q == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: reads one byte at PC, strobes HIR, and maintains the PC.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               FETCH,
  input  logic               JUMP,
  input  logic [ADDR_W-1:0]  JUMP_ADDR,
  input  logic               CLR_ERR,
  fetch_unit_if.master       bus,
  output logic [INSTR_W-1:0] DATA_OUT,
  output logic               HIR,
  output logic [ADDR_W-1:0]  PC,
  output logic               BUSY,
  output logic               ERR
);
  fetch_state_e      state_q, state_d;
  logic              start, ack, tout;
  logic              tmr_clr, tmr_en, tmr_tc;
  logic [ADDR_W-1:0] fetch_addr;

  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CLR     (tmr_clr),
    .EN      (tmr_en),
    .TC      (tmr_tc)
  );

  // A jump in the same cycle as a fetch redirects that fetch.
  assign fetch_addr = JUMP ? JUMP_ADDR : PC;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    ack     = 1'b0;
    tout    = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (FETCH) begin
          state_d = REQ;
          start   = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      REQ: begin
        if (bus.MEM_ACK) begin
          ack     = 1'b1;
          state_d = LOAD;
        end else if (tmr_tc) begin
          tout    = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_en  = 1'b1;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      PC           <= '0;
      bus.MEM_REQ  <= 1'b0;
      bus.MEM_ADDR <= '0;
      DATA_OUT     <= '0;
      ERR          <= 1'b0;
    end else begin
      if (state_q == IDLE && JUMP) PC <= JUMP_ADDR;
      else if (ack)                PC <= bus.MEM_ADDR + 1'b1;

      if (start)            bus.MEM_REQ <= 1'b1;
      else if (ack || tout) bus.MEM_REQ <= 1'b0;

      if (start) bus.MEM_ADDR <= fetch_addr;
      if (ack)   DATA_OUT     <= bus.MEM_RDATA;

      // Timeout set takes priority over a simultaneous clear.
      if (tout)         ERR <= 1'b1;
      else if (CLR_ERR) ERR <= 1'b0;
    end
  end

  assign HIR  = (state_q == LOAD);
  assign BUSY = (state_q != IDLE);
endmodule
